// File: rtl/spi_pwm_pkg.sv
// Shared constants, receiver state encoding and frame sizing
// for the multi-channel SPI-driven PWM slave.
package spi_pwm_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_CS_HIGH = 2'd0,
    IDLE         = 2'd1,
    SHIFT        = 2'd2
  } rx_state_e;

  function automatic int frame_length(input int pwm_width);
    return ADDR_WIDTH + pwm_width;
  endfunction

endpackage

// File: rtl/spi_pwm_frame_receiver.sv
// Oversampling SPI frame receiver: pin synchronisers, edge
// detection and a framing FSM yielding addr/duty pulses.
module spi_frame_receiver
  import spi_pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter int PACK_MSB  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mosi,
  input  logic                  cs,
  input  logic                  sclk,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [PWM_WIDTH-1:0]  duty
);

  localparam int FL = frame_length(PWM_WIDTH);
  localparam int CW = $clog2(FL + 2);
  localparam logic [CW-1:0] FL_C  = CW'(FL);
  localparam logic [CW-1:0] SAT_C = CW'(FL + 1);

  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [1:0]    cs_sync_q, cs_sync_d;
  logic [1:0]    sclk_sync_q, sclk_sync_d;
  logic          cs_prev_q, cs_prev_d;
  logic          sclk_prev_q, sclk_prev_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FL-1:0] sr_q, sr_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic mosi_s, cs_s, sclk_s;
  logic cs_fall, cs_rise, sample_edge;

  assign mosi_s  = mosi_sync_q[1];
  assign cs_s    = cs_sync_q[1];
  assign sclk_s  = sclk_sync_q[1];
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign sample_edge = (CPOL == CPHA) ? (sclk_s & ~sclk_prev_q)
                                      : (~sclk_s & sclk_prev_q);

  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign addr = (PACK_MSB != 0) ? sr_q[FL-1 -: ADDR_WIDTH]
                                : sr_q[ADDR_WIDTH-1:0];
  assign duty = (PACK_MSB != 0) ? sr_q[PWM_WIDTH-1:0]
                                : sr_q[FL-1 -: PWM_WIDTH];

  // Two-flop synchronisers and edge-detect history
  always_comb begin
    mosi_sync_d = {mosi_sync_q[0], mosi};
    cs_sync_d   = {cs_sync_q[0], cs};
    sclk_sync_d = {sclk_sync_q[0], sclk};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
  end

  // Framing FSM: shift on sample edges, judge length at CS rise
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      WAIT_CS_HIGH: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == FL_C) valid_d = 1'b1;
          else               error_d = 1'b1;
        end else if (sample_edge) begin
          if (PACK_MSB != 0) sr_d = {sr_q[FL-2:0], mosi_s};
          else               sr_d = {mosi_s, sr_q[FL-1:1]};
          if (cnt_q != SAT_C) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase
  end

  // Receiver state; CS sync clears low so a live frame is never seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_sync_q <= {CPOL, CPOL};
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= CPOL;
      state_q     <= WAIT_CS_HIGH;
      cnt_q       <= '0;
      sr_q        <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: rtl/spi_slave_pwm_multi.sv
// Multi-channel PWM slave: address decode, double-buffered
// duty registers, shared period counter and comparators.
module spi_slave_pwm_multi
  import spi_pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int PWM_WIDTH = 8,
  parameter int PRESCALE  = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter int PACK_BIT_SEQUENCE_RECEIVE = 1
) (
  input  logic                IN_CLOCK,
  input  logic                IN_RESET_N,
  input  logic                MOSI,
  input  logic                CS,
  input  logic                SCLK,
  output logic [CHANNELS-1:0] OUT_PWM,
  output logic                OUT_FRAME_DONE,
  output logic                OUT_FRAME_ERROR
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic                  rx_valid, rx_error;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [PWM_WIDTH-1:0]  rx_duty;

  logic [PS_W-1:0]      presc_q, presc_d;
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0] shadow_q [CHANNELS];
  logic [PWM_WIDTH-1:0] shadow_d [CHANNELS];
  logic [PWM_WIDTH-1:0] active_q [CHANNELS];
  logic [PWM_WIDTH-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic tick, wrap, is_bcast, in_range;

  spi_frame_receiver #(
    .PWM_WIDTH (PWM_WIDTH),
    .CPOL      (CPOL),
    .CPHA      (CPHA),
    .PACK_MSB  (PACK_BIT_SEQUENCE_RECEIVE)
  ) u_rx (
    .clk         (IN_CLOCK),
    .rst_n       (IN_RESET_N),
    .mosi        (MOSI),
    .cs          (CS),
    .sclk        (SCLK),
    .frame_valid (rx_valid),
    .frame_error (rx_error),
    .addr        (rx_addr),
    .duty        (rx_duty)
  );

  assign tick     = (presc_q == PS_MAX);
  assign wrap     = tick && (cnt_q == '1);
  assign is_bcast = (rx_addr == BROADCAST_ADDR);
  assign in_range = (int'(rx_addr) < CHANNELS);

  assign OUT_PWM         = pwm_q;
  assign OUT_FRAME_DONE  = done_q;
  assign OUT_FRAME_ERROR = err_q;

  // Frame decode into shadow registers
  always_comb begin
    shadow_d = shadow_q;
    done_d   = 1'b0;
    err_d    = rx_error;
    if (rx_valid) begin
      unique case (1'b1)
        is_bcast: begin
          for (int k = 0; k < CHANNELS; k++) shadow_d[k] = rx_duty;
          done_d = 1'b1;
        end
        in_range: begin
          for (int k = 0; k < CHANNELS; k++)
            if (rx_addr == ADDR_WIDTH'(k)) shadow_d[k] = rx_duty;
          done_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Shared timebase, period-boundary load and comparators
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
    active_d = active_q;
    if (wrap) active_d = shadow_q;
    for (int k = 0; k < CHANNELS; k++)
      pwm_d[k] = (cnt_q < active_q[k]);
  end

  // Register file, timebase and output flops
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      presc_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      pwm_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
